// File: rtl/uart_block_sender_if.sv
// Block/transmitter handshake bundle for uart_block_sender.
// slave = the sender itself; master = block source plus UART TX.
interface uart_block_sender_if #(
    parameter int BLOCK_BYTES = 16
);
    logic                     i_blk_valid;
    logic [8*BLOCK_BYTES-1:0] i_blk_data;
    logic                     o_blk_ready;
    logic                     o_tx_start;
    logic [7:0]               o_tx_byte;
    logic                     i_tx_busy;
    logic                     o_busy;
    logic                     o_done;

    modport slave (
        input  i_blk_valid, i_blk_data, i_tx_busy,
        output o_blk_ready, o_tx_start, o_tx_byte, o_busy, o_done
    );

    modport master (
        output i_blk_valid, i_blk_data, i_tx_busy,
        input  o_blk_ready, o_tx_start, o_tx_byte, o_busy, o_done
    );
endinterface

// File: rtl/uart_block_sender.sv
// Serialises one BLOCK_BYTES block into byte starts for a UART TX, MSB byte first.
// Define UART_CHKSUM_EN to append an XOR-of-payload checksum byte to every block.
//
// state     | meaning
// IDLE      | ready for a block
// WAIT_IDLE | waiting for transmitter idle, then issue start
// WAIT_HI   | start issued, waiting for busy to rise (retry on silence)
// WAIT_LO   | byte in flight, waiting for busy to fall
// GAP       | GAP_CLKS idle clocks after the fall
// NEXT      | advance to next byte or finish the block
// DONE      | o_done pulse, o_busy still high
module uart_block_sender #(
    parameter int BLOCK_BYTES = 16,
    parameter int GAP_CLKS    = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    uart_block_sender_if.slave bus
);
    localparam int DW = 8 * BLOCK_BYTES;
    localparam int IW = $clog2(BLOCK_BYTES + 1);
    localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_IDLE, WAIT_HI, WAIT_LO, GAP, NEXT, DONE
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [DW-1:0]   r_data,     w_data_nxt;
    logic [IW-1:0]   r_idx,      w_idx_nxt;
    logic [GW-1:0]   r_gap,      w_gap_nxt;
    logic [1:0]      r_hi_cnt,   w_hi_cnt_nxt;
    logic [1:0]      r_retry,    w_retry_nxt;
    logic            r_tx_start, w_tx_start_nxt;
    logic [7:0]      r_tx_byte,  w_tx_byte_nxt;
    logic            r_busy,     w_busy_nxt;
    logic            r_done,     w_done_nxt;
    logic [7:0]      w_cur_byte;
    logic            w_last;
`ifdef UART_CHKSUM_EN
    logic [7:0]      r_xor,      w_xor_nxt;
    logic            r_chk,      w_chk_nxt;

    assign w_cur_byte = r_chk ? r_xor : r_data[DW-1 -: 8];
`else
    assign w_cur_byte = r_data[DW-1 -: 8];
`endif

    assign w_last          = (r_idx == IW'(BLOCK_BYTES - 1));
    assign bus.o_blk_ready = (r_state == IDLE);
    assign bus.o_tx_start  = r_tx_start;
    assign bus.o_tx_byte   = r_tx_byte;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_idx      <= '0;
            r_gap      <= '0;
            r_hi_cnt   <= '0;
            r_retry    <= '0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_CHKSUM_EN
            r_xor      <= '0;
            r_chk      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_idx      <= w_idx_nxt;
            r_gap      <= w_gap_nxt;
            r_hi_cnt   <= w_hi_cnt_nxt;
            r_retry    <= w_retry_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
`ifdef UART_CHKSUM_EN
            r_xor      <= w_xor_nxt;
            r_chk      <= w_chk_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_idx_nxt      = r_idx;
        w_gap_nxt      = r_gap;
        w_hi_cnt_nxt   = r_hi_cnt;
        w_retry_nxt    = r_retry;
        w_tx_start_nxt = 1'b0;
        w_tx_byte_nxt  = r_tx_byte;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
`ifdef UART_CHKSUM_EN
        w_xor_nxt      = r_xor;
        w_chk_nxt      = r_chk;
`endif
        case (r_state)
            IDLE: begin
                if (bus.i_blk_valid) begin
                    w_data_nxt  = bus.i_blk_data;
                    w_idx_nxt   = '0;
                    w_retry_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = WAIT_IDLE;
`ifdef UART_CHKSUM_EN
                    w_xor_nxt   = '0;
                    w_chk_nxt   = 1'b0;
`endif
                end
            end
            WAIT_IDLE: begin
                if (!bus.i_tx_busy) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_byte_nxt  = w_cur_byte;
                    w_hi_cnt_nxt   = '0;
                    w_state_nxt    = WAIT_HI;
`ifdef UART_CHKSUM_EN
                    // a retry re-sends the same byte, so fold it in only once
                    if (!r_chk && r_retry == 2'd0)
                        w_xor_nxt = r_xor ^ w_cur_byte;
`endif
                end
            end
            WAIT_HI: begin
                if (bus.i_tx_busy) begin
                    w_retry_nxt = '0;
                    w_state_nxt = WAIT_LO;
                end else if (r_hi_cnt == 2'd3) begin
                    if (r_retry == 2'd2) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_retry_nxt = r_retry + 2'd1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end else begin
                    w_hi_cnt_nxt = r_hi_cnt + 2'd1;
                end
            end
            WAIT_LO: begin
                if (!bus.i_tx_busy) begin
                    if (GAP_CLKS > 0) begin
                        w_gap_nxt   = GW'(GAP_CLKS);
                        w_state_nxt = GAP;
                    end else begin
                        w_state_nxt = NEXT;
                    end
                end
            end
            GAP: begin
                if (r_gap <= GW'(1)) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = NEXT;
                end else begin
                    w_gap_nxt = r_gap - GW'(1);
                end
            end
            NEXT: begin
`ifdef UART_CHKSUM_EN
                if (r_chk) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_last) begin
                    w_chk_nxt   = 1'b1;
                    w_state_nxt = WAIT_IDLE;
                end
`else
                if (w_last) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end
`endif
                else begin
                    w_idx_nxt   = r_idx + IW'(1);
                    w_data_nxt  = r_data << 8;
                    w_state_nxt = WAIT_IDLE;
                end
            end
            DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/uart_block_sender.md
Name: uart_block_sender

Overview:
Serialises one multi-byte block, by default a 128-bit AES-256 ciphertext, into single-byte transfers for the byte-wide UART transmitter.
- Accepts a whole block on a valid/ready handshake.
- Issues one-cycle start pulses with byte data to the transmitter.
- Tracks the transmitter busy flag so bytes are never dropped or overlapped.
- Sits between the AES core output and the UART TX serialiser.

Parameters:
BLOCK_BYTES, 16, number of bytes per block; legal range 1..32.
GAP_CLKS, 0, idle clocks inserted after each byte's busy falls, before the next start; 0 means no gap.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_blk_valid  input  1  block offered
i_blk_data  input  8*BLOCK_BYTES  block payload; byte 0 = bits [8*BLOCK_BYTES-1 -: 8] (MSB byte first)
o_blk_ready  output  1  block accepted this cycle when i_blk_valid=1
o_tx_start  output  1  one-cycle start pulse to the transmitter
o_tx_byte  output  8  byte for the transmitter; stable from the start pulse until busy falls
i_tx_busy  input  1  transmitter busy flag
o_busy  output  1  high from acceptance until the done pulse inclusive
o_done  output  1  one-cycle pulse after the last byte's busy falls

Behaviour:
- Reset (asynchronous, i_rst_n=0): state=IDLE, o_tx_start=0, o_tx_byte=0, o_done=0, o_busy=0, byte index=0, gap counter=0. o_blk_ready=1 after reset.
- Reset mid-block aborts the block. Bytes not yet started are discarded. No start pulse is issued during or after reset.
- The transmitter has no reset, so it may still be busy after a reset. This is handled by the WAIT_IDLE rule below.
- All outputs are registered except o_blk_ready, which equals (state==IDLE).
- IDLE:
  - o_blk_ready=1.
  - On i_blk_valid & o_blk_ready: capture i_blk_data into the holding register, idx=0, o_busy=1, go to WAIT_IDLE.
  - i_blk_data is ignored at all other times.
- WAIT_IDLE:
  - If i_tx_busy=0: drive o_tx_start=1 for exactly one cycle, load o_tx_byte=byte[idx], go to WAIT_HI.
  - Otherwise hold.
- WAIT_HI:
  - Wait for i_tx_busy=1, which the transmitter asserts 1 clock after the start pulse.
  - o_tx_start is 0 here.
  - If busy stays 0 for 4 consecutive cycles, re-issue the same start pulse once (return to WAIT_IDLE) and increment the internal retry counter.
  - After 2 retries with no busy, abandon the block: o_done pulses and the state returns to IDLE.
- WAIT_LO:
  - Wait for i_tx_busy=0.
  - On the fall, go to GAP if GAP_CLKS>0; otherwise go to NEXT in the same step.
- GAP: count GAP_CLKS cycles, then go to NEXT.
- NEXT:
  - If idx==BLOCK_BYTES-1 (or the checksum stage is finished, see the optional feature): o_done=1 for 1 cycle, o_busy=0 in the following cycle, go to IDLE.
  - Otherwise idx+1, go to WAIT_IDLE.
- Minimum inter-start spacing: start, 1 cycle, busy high, busy low, NEXT, WAIT_IDLE, start. This is at least 3 clocks plus the transmitter's busy time.
- i_tx_busy high while in IDLE is ignored.
- o_blk_ready is not asserted in the same cycle as o_done; the next block can be accepted 1 cycle after o_done.
- idx width is $clog2(BLOCK_BYTES+1). There is no wrap; idx is reloaded only on acceptance.

Optional Feature:
Macro UART_CHKSUM_EN.
- When defined:
  - A running XOR of all payload bytes is kept, cleared on acceptance and updated on each payload start pulse.
  - After the last payload byte, one extra byte is sent through the normal WAIT_IDLE/WAIT_HI/WAIT_LO/GAP path: the XOR value. A block is therefore BLOCK_BYTES+1 starts.
  - o_done fires after the checksum byte's busy falls.
- When undefined: no XOR register; exactly BLOCK_BYTES starts per block.

Test Plan:
Bench uses a transmitter model that raises busy 1 clock after start and holds it 20 clocks. Default parameters unless stated.
1. Block 0x00112233445566778899AABBCCDDEEFF, valid for 1 cycle in IDLE -> 16 start pulses, bytes 0x00,0x11,...,0xFF in order; each start only while busy=0; o_done once; o_busy high throughout.
2. Same block with UART_CHKSUM_EN defined -> 17 starts; final byte 0x00 (XOR of all payload bytes); o_done after the 17th busy falls.
3. Model busy held high 50 clocks out of reset, then a block offered -> no start until busy=0; first start 1 cycle after busy falls.
4. Assert i_rst_n=0 during the 5th byte's busy window -> outputs go to reset values immediately; no further starts; after release, a new block 0xA5 repeated sends 16 bytes of 0xA5.
5. Model never asserts busy -> exactly 3 start pulses for byte 0, spaced 5 cycles apart; o_done pulses; o_blk_ready returns to 1.
6. GAP_CLKS=8, back-to-back blocks with i_blk_valid held high -> at least 8 idle clocks between each busy fall and the next start; second block accepted 1 cycle after the first o_done.
